// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEFAULT = 8;
  localparam int BURST_MAX_DEFAULT = 4;
  localparam int CNT_SIZE_DEFAULT  = 8;

  localparam int REQ_CPU = 0;
  localparam int REQ_LDR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// Burst length counter: clears on ownership change, counts accesses and
// saturates at burst_max-1, where it raises the terminal-count flag.
module arb_burst_counter #(
  parameter int cnt_size  = 8,
  parameter int burst_max = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic incr_i,
  output logic terminal_o
);

  localparam logic [cnt_size-1:0] LastCount = cnt_size'(burst_max - 1);

  logic [cnt_size-1:0] count_q;
  logic [cnt_size-1:0] count_d;

  assign terminal_o = (count_q == LastCount);

  // Holding at the terminal value lets a lone owner keep the port indefinitely.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && !terminal_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the processor
// (requester 0) and the loader/debug port (requester 1), with bounded bursts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int word_size = WORD_SIZE_DEFAULT,
  parameter int burst_max = BURST_MAX_DEFAULT,
  parameter int cnt_size  = CNT_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_0,
  input  logic                 we_0,
  input  logic [word_size-1:0] addr_0,
  input  logic [word_size-1:0] wdata_0,
  output logic                 gnt_0,
  input  logic                 req_1,
  input  logic                 we_1,
  input  logic [word_size-1:0] addr_1,
  input  logic [word_size-1:0] wdata_1,
  output logic                 gnt_1,
  output logic [word_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_word,
  output logic [word_size-1:0] rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       lastOwner_q;
  logic       lastOwner_d;
  logic       access;
  logic       terminal;
  logic       stateChange;

  assign access      = (gnt0_q & req_0) | (gnt1_q & req_1);
  assign stateChange = (state_d != state_q);

  arb_burst_counter #(
    .cnt_size  (cnt_size),
    .burst_max (burst_max)
  ) u_burst_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clear_i    (stateChange),
    .incr_i     (access),
    .terminal_o (terminal)
  );

  // Ties in IDLE go to the requester that did not own the port last.
  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    case (state_q)
      IDLE: begin
        if (req_0 && req_1) begin
          state_d = lastOwner_q ? OWN0 : OWN1;
        end else if (req_0) begin
          state_d = OWN0;
        end else if (req_1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req_0) begin
          state_d = req_1 ? OWN1 : IDLE;
        end else if (terminal && req_1) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!req_1) begin
          state_d = req_0 ? OWN0 : IDLE;
        end else if (terminal && req_0) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == OWN0 && state_d != OWN0) begin
      lastOwner_d = 1'(REQ_CPU);
    end else if (state_q == OWN1 && state_d != OWN1) begin
      lastOwner_d = 1'(REQ_LDR);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      lastOwner_q <= 1'(REQ_LDR);
    end else begin
      state_q     <= state_d;
      gnt0_q      <= (state_d == OWN0);
      gnt1_q      <= (state_d == OWN1);
      lastOwner_q <= lastOwner_d;
    end
  end

  assign gnt_0 = gnt0_q;
  assign gnt_1 = gnt1_q;

  // The memory side follows the registered grant so a request cannot glitch it.
  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_write   = 1'b0;
    if (gnt0_q) begin
      mem_address = addr_0;
      mem_data_in = wdata_0;
      mem_write   = we_0 & req_0;
    end else if (gnt1_q) begin
      mem_address = addr_1;
      mem_data_in = wdata_1;
      mem_write   = we_1 & req_1;
    end
  end

  assign rdata = mem_word;

  assert property (@(posedge clk) disable iff (!rst) !(gnt_0 && gnt_1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scripted scoreboard bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic       req_0, we_0, req_1, we_1;
  logic [7:0] addr_0, wdata_0, addr_1, wdata_1;
  logic       gnt_0, gnt_1, mem_write;
  logic [7:0] mem_address, mem_data_in, mem_word, rdata;

  logic [7:0] memArr [256];

  int checks   = 0;
  int failures = 0;
  int cycleNum = 0;

  typedef struct {
    int         cyc;
    logic       g0;
    logic       g1;
    logic       mw;
    logic [7:0] addr;
    logic [7:0] din;
    logic       chkRd;
    logic [7:0] rd;
  } exp_t;

  exp_t expQ[$];

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_0       (req_0),
    .we_0        (we_0),
    .addr_0      (addr_0),
    .wdata_0     (wdata_0),
    .gnt_0       (gnt_0),
    .req_1       (req_1),
    .we_1        (we_1),
    .addr_1      (addr_1),
    .wdata_1     (wdata_1),
    .gnt_1       (gnt_1),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_write   (mem_write),
    .mem_word    (mem_word),
    .rdata       (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_word = memArr[mem_address];

  always @(posedge clk) begin
    if (mem_write === 1'b1) memArr[mem_address] <= mem_data_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN,
                               input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                               input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    rst = rstN;
    req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
    req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
  endtask

  // Expected grants are scripted; the memory-side values follow from them.
  task automatic expectCycle(input logic g0, input logic g1,
                             input logic chkRd, input logic [7:0] rd);
    exp_t e;
    exp_t o;
    cycleNum++;
    e.cyc   = cycleNum;
    e.g0    = g0;
    e.g1    = g1;
    e.addr  = g0 ? addr_0 : (g1 ? addr_1 : 8'h00);
    e.din   = g0 ? wdata_0 : (g1 ? wdata_1 : 8'h00);
    e.mw    = g0 ? (we_0 & req_0) : (g1 ? (we_1 & req_1) : 1'b0);
    e.chkRd = chkRd;
    e.rd    = rd;
    expQ.push_back(e);
    @(negedge clk);
    o = expQ.pop_front();
    checkOutput($sformatf("c%0d gnt_0", o.cyc), 32'(gnt_0), 32'(o.g0));
    checkOutput($sformatf("c%0d gnt_1", o.cyc), 32'(gnt_1), 32'(o.g1));
    checkOutput($sformatf("c%0d mem_write", o.cyc), 32'(mem_write), 32'(o.mw));
    checkOutput($sformatf("c%0d mem_address", o.cyc), 32'(mem_address), 32'(o.addr));
    checkOutput($sformatf("c%0d mem_data_in", o.cyc), 32'(mem_data_in), 32'(o.din));
    if (o.chkRd) checkOutput($sformatf("c%0d rdata", o.cyc), 32'(rdata), 32'(o.rd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 8'h00;

    // Reset held with both requests high
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h30, 8'h77);
    @(posedge clk);
    #1;
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h30, 8'h77);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);

    // Continuous contention: bursts of four alternate with no idle cycle
    for (int i = 0; i < 4; i++) expectCycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) expectCycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) expectCycle(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h30, 8'h77);
    expectCycle(1'b0, 1'b1, 1'b0, 8'h00);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("mem[30] after loader burst", 32'(memArr[8'h30]), 32'h77);

    // Single loader write then read-back
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);
    expectCycle(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h10, 8'hA5);
    expectCycle(1'b0, 1'b1, 1'b1, 8'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h10, 8'hA5);
    expectCycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Processor alone for ten accesses, then a late loader request
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) expectCycle(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    expectCycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Processor write attempted while the loader owns the port
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h50, 8'h3C, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 4; i++) expectCycle(1'b0, 1'b1, 1'b1, 8'hA5);
    checkOutput("mem[50] before processor grant", 32'(memArr[8'h50]), 32'h00);
    expectCycle(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h50, 8'h3C, 1'b1, 1'b0, 8'h10, 8'h00);
    expectCycle(1'b1, 1'b0, 1'b1, 8'h3C);

    // Reset during the second access of a loader burst
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h50, 8'h3C, 1'b1, 1'b1, 8'h60, 8'h99);
    expectCycle(1'b1, 1'b0, 1'b0, 8'h00);
    expectCycle(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b1, 8'h61, 8'h5A);
    expectCycle(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b0, 8'h61, 8'h00);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);
    expectCycle(1'b1, 1'b0, 1'b1, 8'h99);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h61, 8'h00, 1'b1, 1'b0, 8'h61, 8'h00);
    expectCycle(1'b1, 1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    expectCycle(1'b1, 1'b0, 1'b0, 8'h00);
    expectCycle(1'b0, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
